// File: rtl/collision_probe_scanner.sv
// Collision map prober: four ROM probes per character box per scan,
// results published atomically with a one-cycle valid strobe.
module collision_probe_scanner #(
  parameter int NUM_CHARS = 2,
  parameter int COORD_W   = 10,
  parameter int DATA_W    = 3,
  parameter int ADDR_W    = 19,
  parameter int MAP_W     = 640,
  parameter int MAP_H     = 480,
  parameter int ROM_LAT   = 3,
  parameter logic [NUM_CHARS*COORD_W-1:0] X_OFF = {10'd25, 10'd13},
  parameter logic [NUM_CHARS*COORD_W-1:0] Y_OFF = {10'd25, 10'd15}
) (
  input  logic                          vga_clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          free_run,
  input  logic [NUM_CHARS*COORD_W-1:0]  box_left,
  input  logic [NUM_CHARS*COORD_W-1:0]  box_right,
  input  logic [NUM_CHARS*COORD_W-1:0]  box_top,
  input  logic [NUM_CHARS*COORD_W-1:0]  box_bottom,
  output logic [ADDR_W-1:0]             rom_addr,
  input  logic [DATA_W-1:0]             rom_data,
  output logic                          busy,
  output logic                          res_valid,
  output logic [NUM_CHARS*4*DATA_W-1:0] probe_res
);

  localparam int P  = 4 * NUM_CHARS;
  localparam int KW = $clog2(P);
  localparam int WW = $clog2(ROM_LAT);
  localparam int CW = NUM_CHARS * COORD_W;
  localparam int RW = P * DATA_W;

  localparam logic [COORD_W:0] LP_W =
    (COORD_W+1)'(MAP_W);
  localparam logic [COORD_W:0] LP_H =
    (COORD_W+1)'(MAP_H);
  localparam logic [ADDR_W-1:0] LP_MW =
    ADDR_W'(MAP_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SCAN,
    S_PUB
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]     r_l;
  logic [CW-1:0]     r_r;
  logic [CW-1:0]     r_t;
  logic [CW-1:0]     r_b;
  logic [KW-1:0]     r_k;
  logic [WW-1:0]     r_w;
  logic [RW-1:0]     r_shadow;
  logic [RW-1:0]     r_res;
  logic [ADDR_W-1:0] r_addr;
  logic              r_valid;

  logic              w_go;
  logic              w_cap;
  logic              w_last;
  logic [KW-1:0]     w_sel;
  logic [KW-1:0]     w_ci;
  logic [1:0]        w_pj;
  logic [COORD_W-1:0] w_bl;
  logic [COORD_W-1:0] w_br;
  logic [COORD_W-1:0] w_bt;
  logic [COORD_W-1:0] w_bb;
  logic [COORD_W-1:0] w_xo;
  logic [COORD_W-1:0] w_yo;
  logic [COORD_W:0]  w_xe;
  logic [COORD_W:0]  w_ys;
  logic [COORD_W:0]  w_x;
  logic [COORD_W:0]  w_y;
  logic [COORD_W:0]  w_xc;
  logic [COORD_W:0]  w_yc;
  logic [ADDR_W-1:0] w_addr;

  assign w_go   = start | free_run;
  assign w_cap  = (r_state == S_SCAN) &&
                  (r_w == WW'(ROM_LAT - 1));
  assign w_last = (r_k == KW'(P - 1));

  // LOAD issues probe 0; each SCAN capture issues the next probe
  assign w_sel = (r_state == S_LOAD) ? '0 : r_k + 1'b1;
  assign w_ci  = w_sel >> 2;
  assign w_pj  = w_sel[1:0];

  assign w_bl = r_l[w_ci*COORD_W +: COORD_W];
  assign w_br = r_r[w_ci*COORD_W +: COORD_W];
  assign w_bt = r_t[w_ci*COORD_W +: COORD_W];
  assign w_bb = r_b[w_ci*COORD_W +: COORD_W];
  assign w_xo = X_OFF[w_ci*COORD_W +: COORD_W];
  assign w_yo = Y_OFF[w_ci*COORD_W +: COORD_W];

  assign w_xe = {1'b0, w_bl} + {1'b0, w_xo};
  assign w_ys = {1'b0, w_bb} - {1'b0, w_yo};

  // Raw probe coordinate; top edge beyond the map is a wrapped negative
  always_comb begin
    w_x = '0;
    w_y = '0;
    unique case (w_pj)
      2'd0: begin
        w_x = {1'b0, w_bl};
        w_y = (w_bb < w_yo) ? '0 : w_ys;
      end
      2'd1: begin
        w_x = {1'b0, w_br};
        w_y = (w_bb < w_yo) ? '0 : w_ys;
      end
      2'd2: begin
        w_x = w_xe;
        w_y = ({1'b0, w_bt} >= LP_H) ?
              '0 : {1'b0, w_bt};
      end
      default: begin
        w_x = w_xe;
        w_y = {1'b0, w_bb};
      end
    endcase
  end

  assign w_xc = (w_x >= LP_W) ? LP_W - 1'b1 : w_x;
  assign w_yc = (w_y >= LP_H) ? LP_H - 1'b1 : w_y;

  assign w_addr = ADDR_W'(w_yc) * LP_MW +
                  ADDR_W'(w_xc);

  // State register
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state sequencing
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_go) w_next = S_LOAD;
      S_LOAD: w_next = S_SCAN;
      S_SCAN: if (w_cap && w_last) w_next = S_PUB;
      S_PUB:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Snapshot, address issue, capture and publish
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_l      <= '0;
      r_r      <= '0;
      r_t      <= '0;
      r_b      <= '0;
      r_k      <= '0;
      r_w      <= '0;
      r_shadow <= '0;
      r_res    <= '0;
      r_addr   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_l <= box_left;
            r_r <= box_right;
            r_t <= box_top;
            r_b <= box_bottom;
          end
        end
        S_LOAD: begin
          r_addr <= w_addr;
          r_k    <= '0;
          r_w    <= '0;
        end
        S_SCAN: begin
          if (w_cap) begin
            r_shadow[r_k*DATA_W +: DATA_W] <= rom_data;
            r_w <= '0;
            if (!w_last) begin
              r_addr <= w_addr;
              r_k    <= r_k + 1'b1;
            end
          end else begin
            r_w <= r_w + 1'b1;
          end
        end
        S_PUB: begin
          r_res   <= r_shadow;
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rom_addr  = r_addr;
  assign busy      = (r_state != S_IDLE);
  assign res_valid = r_valid;
  assign probe_res = r_res;

endmodule

// File: tb/tb_collision_probe_scanner.sv
// Bench for collision_probe_scanner: table vectors, random scans
// against a coordinate model, free-run, snapshot and reset cases.
module tb_collision_probe_scanner;

  localparam int W  = 640;
  localparam int H  = 480;
  localparam int XO [2] = '{13, 25};
  localparam int YO [2] = '{15, 25};

  typedef int boxes_t [4][2];
  typedef int a8_t [8];

  typedef struct {
    int l0, r0, t0, b0;
    int l1, r1, t1, b1;
    int ch;
    int e0, e1, e2, e3;
  } vec_t;

  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        free_run = 1'b0;
  logic [19:0] box_left = '0;
  logic [19:0] box_right = '0;
  logic [19:0] box_top = '0;
  logic [19:0] box_bottom = '0;
  logic [18:0] rom_addr;
  logic [2:0]  rom_data;
  logic        busy;
  logic        res_valid;
  logic [23:0] probe_res;

  logic [18:0] rp1, rp2;

  int n_cmp = 0;
  int n_err = 0;

  collision_probe_scanner dut (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .start      (start),
    .free_run   (free_run),
    .box_left   (box_left),
    .box_right  (box_right),
    .box_top    (box_top),
    .box_bottom (box_bottom),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .busy       (busy),
    .res_valid  (res_valid),
    .probe_res  (probe_res)
  );

  always #5 vga_clk = ~vga_clk;

  // ROM: data for an address is capturable ROM_LAT edges after issue
  always @(posedge vga_clk) begin
    rp1 <= rom_addr;
    rp2 <= rp1;
  end
  assign rom_data = rp2[2:0];

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic int m_addr(input boxes_t a,
                                input int i, input int j);
    int x, y;
    x = 0;
    y = 0;
    case (j)
      0: begin x = a[0][i]; y = a[3][i] - YO[i]; end
      1: begin x = a[1][i]; y = a[3][i] - YO[i]; end
      2: begin
        x = a[0][i] + XO[i];
        y = (a[2][i] >= H) ? 0 : a[2][i];
      end
      default: begin
        x = a[0][i] + XO[i];
        y = a[3][i];
      end
    endcase
    if (y < 0) y = 0;
    if (x >= W) x = W - 1;
    if (y >= H) y = H - 1;
    return (y * W + x) % (1 << 19);
  endfunction

  function automatic logic [23:0] m_res(input boxes_t a);
    logic [23:0] r;
    int v;
    r = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 4; j++) begin
        v = m_addr(a, i, j);
        r[(4*i+j)*3 +: 3] = v[2:0];
      end
    return r;
  endfunction

  task automatic drive(input boxes_t a);
    for (int i = 0; i < 2; i++) begin
      box_left[i*10 +: 10]   = a[0][i][9:0];
      box_right[i*10 +: 10]  = a[1][i][9:0];
      box_top[i*10 +: 10]    = a[2][i][9:0];
      box_bottom[i*10 +: 10] = a[3][i][9:0];
    end
  endtask

  task automatic rand_boxes(output boxes_t a);
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < 2; i++)
        a[f][i] = int'($urandom_range(0, 1023));
  endtask

  task automatic do_scan(input boxes_t a, input int chg,
                         input boxes_t nb,
                         output logic [23:0] res,
                         output a8_t got);
    int cyc, n, e, holdbad, busybad;
    logic [23:0] exp;
    exp = m_res(a);
    holdbad = 0;
    busybad = 0;
    for (int q = 0; q < 8; q++) got[q] = -1;
    drive(a);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    if (busy !== 1'b1) busybad++;
    while (res_valid !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
      if (cyc == chg) drive(nb);
      if (res_valid !== 1'b1 && busy !== 1'b1)
        busybad++;
      if (cyc >= 2 && cyc <= 25) begin
        n = (cyc - 2) / 3;
        e = m_addr(a, n / 4, n % 4);
        if ((cyc - 2) % 3 == 0) begin
          got[n] = int'(rom_addr);
          check("addr", 64'(rom_addr), 64'(e));
        end else if (int'(rom_addr) != e) begin
          holdbad++;
        end
      end
    end
    check("latency", 64'(cyc), 64'd27);
    check("busy_scan", 64'(busybad), 64'd0);
    check("addr_hold", 64'(holdbad), 64'd0);
    check("busy_pub", 64'(busy), 64'd0);
    check("res", 64'(probe_res), 64'(exp));
    res = probe_res;
    tick();
    check("pulse_len", 64'(res_valid), 64'd0);
    check("res_hold", 64'(probe_res), 64'(exp));
  endtask

  vec_t        tab [5];
  boxes_t      bx, nb;
  a8_t         got;
  logic [23:0] res;
  int          ev [4];
  int          cyc, pulses, last, seen;

  initial begin
    tab[0] = '{100, 120, 200, 230, 0, 0, 0, 100,
               0, 137700, 137720, 128113, 147313};
    tab[1] = '{10, 20, 30, 40, 630, 700, 1020, 10,
               1, 630, 639, 639, 7039};
    tab[2] = '{5, 6, 7, 8, 50, 60, 400, 500,
               1, 304050, 304060, 256075, 306635};
    tab[3] = '{626, 639, 479, 15, 1, 2, 3, 30,
               0, 626, 639, 307199, 10239};
    tab[4] = '{0, 5, 480, 14, 9, 9, 9, 9,
               0, 0, 5, 13, 8973};

    #12;
    check("rst_addr", 64'(rom_addr), 64'd0);
    check("rst_res", 64'(probe_res), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(res_valid), 64'd0);
    reset_n = 1'b1;
    tick();
    tick();
    check("idle_busy", 64'(busy), 64'd0);

    for (int v = 0; v < 5; v++) begin
      bx[0][0] = tab[v].l0; bx[1][0] = tab[v].r0;
      bx[2][0] = tab[v].t0; bx[3][0] = tab[v].b0;
      bx[0][1] = tab[v].l1; bx[1][1] = tab[v].r1;
      bx[2][1] = tab[v].t1; bx[3][1] = tab[v].b1;
      ev[0] = tab[v].e0; ev[1] = tab[v].e1;
      ev[2] = tab[v].e2; ev[3] = tab[v].e3;
      do_scan(bx, 0, bx, res, got);
      for (int j = 0; j < 4; j++) begin
        check("tab_addr", 64'(got[tab[v].ch*4+j]),
              64'(ev[j]));
        check("tab_data",
              64'(res[(4*tab[v].ch+j)*3 +: 3]),
              64'(ev[j][2:0]));
      end
      tick();
    end

    for (int r = 0; r < 12; r++) begin
      rand_boxes(bx);
      do_scan(bx, 0, bx, res, got);
      repeat ($urandom_range(0, 3)) tick();
    end

    rand_boxes(bx);
    rand_boxes(nb);
    do_scan(bx, 5, nb, res, got);
    do_scan(nb, 0, nb, res, got);

    rand_boxes(bx);
    drive(bx);
    free_run = 1'b1;
    cyc = 0;
    pulses = 0;
    last = 0;
    while (pulses < 3 && cyc < 200) begin
      start = (cyc == 10 || cyc == 40);
      tick();
      cyc++;
      if (res_valid === 1'b1) begin
        pulses++;
        if (pulses == 1)
          check("fr_first", 64'(cyc), 64'd27);
        else
          check("fr_period", 64'(cyc - last), 64'd27);
        check("fr_res", 64'(probe_res), 64'(m_res(bx)));
        last = cyc;
      end
    end
    free_run = 1'b0;
    start = 1'b0;
    check("fr_pulses", 64'(pulses), 64'd3);
    seen = 0;
    repeat (30) begin
      tick();
      if (res_valid === 1'b1 || busy === 1'b1) seen++;
    end
    check("fr_stop", 64'(seen), 64'd0);

    rand_boxes(bx);
    bx[0][0] = 300;
    bx[3][0] = 300;
    drive(bx);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("pre_rst_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_addr", 64'(rom_addr), 64'd0);
    check("mid_rst_res", 64'(probe_res), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_valid", 64'(res_valid), 64'd0);
    seen = 0;
    repeat (3) begin
      tick();
      if (res_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    reset_n = 1'b1;
    repeat (40) begin
      tick();
      if (res_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    check("rst_quiet", 64'(seen), 64'd0);
    rand_boxes(bx);
    do_scan(bx, 0, bx, res, got);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
